// File: rtl/microwave_pkg.sv
// Shared microwave definitions: keypad timing, sequencer state encoding and
// BCD helpers used by both the key sequencer and the keypad decoder.
package microwave_pkg;

    localparam int PRESS_CYC       = 5;
    localparam int GAP_CYC         = 15;
    localparam int START_WAIT_CYC  = 20;
    localparam int START_PRESS_CYC = 5;
    localparam int CNT_W           = 5;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        START_WAIT,
        START_PRESS,
        DONE
    } seq_state_e;

    // Out-of-range codes map to no key rather than aliasing onto a real one.
    function automatic logic [9:0] bcd_to_onehot(input logic [3:0] d);
        bcd_to_onehot = (d <= 4'd9) ? (10'd1 << d) : 10'd0;
    endfunction

    function automatic logic digits_valid(input logic [3:0] m,
                                          input logic [3:0] st,
                                          input logic [3:0] so);
        digits_valid = (m <= 4'd9) && (st <= 4'd5) && (so <= 4'd9);
    endfunction

    // Timer reload value on entry: a state lasting N cycles loads N-1.
    function automatic logic [CNT_W-1:0] state_dur(input seq_state_e s);
        case (s)
            PRESS:       state_dur = CNT_W'(PRESS_CYC - 1);
            GAP:         state_dur = CNT_W'(GAP_CYC - 1);
            START_WAIT:  state_dur = CNT_W'(START_WAIT_CYC - 1);
            START_PRESS: state_dur = CNT_W'(START_PRESS_CYC - 1);
            default:     state_dur = '0;
        endcase
    endfunction

endpackage

// File: rtl/key_sequencer_if.sv
// Request/status bundle between a time-entry controller and the key sequencer.
interface key_sequencer_if;
    logic       go;
    logic [3:0] min_digit;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [9:0] keys;
    logic       startn;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output go, min_digit, sec_tens, sec_ones,
                    input  keys, startn, busy, done, err);
    modport slave  (input  go, min_digit, sec_tens, sec_ones,
                    output keys, startn, busy, done, err);
endinterface

// File: rtl/key_timer.sv
// Loadable down-counter; zero flag tells the sequencer its current state has expired.
module key_timer
    import microwave_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/key_sequencer.sv
// Converts a BCD cook time M:ST into timed keypad presses followed by a start press.
module key_sequencer
    import microwave_pkg::*;
(
    input  logic      clock,
    input  logic      resetn,
    key_sequencer_if.slave bus
);
    seq_state_e       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0][3:0]  dig_q, dig_d;
    logic [9:0]       keys_q, keys_d;
    logic             startn_q, startn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tmr_load, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    key_timer u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dig_d   = dig_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.go) begin
                if (digits_valid(bus.min_digit, bus.sec_tens, bus.sec_ones)) begin
                    state_d = PRESS;
                    idx_d   = 2'd0;
                    dig_d   = {bus.sec_ones, bus.sec_tens, bus.min_digit};
                end else begin
                    err_d = 1'b1;
                end
            end
            PRESS:       if (tmr_zero) state_d = (idx_q == 2'd2) ? START_WAIT : GAP;
            GAP:         if (tmr_zero) begin
                state_d = PRESS;
                idx_d   = idx_q + 2'd1;
            end
            START_WAIT:  if (tmr_zero) state_d = START_PRESS;
            START_PRESS: if (tmr_zero) state_d = DONE;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up with it.
        keys_d   = (state_d == PRESS) ? bcd_to_onehot(dig_d[idx_d]) : 10'd0;
        startn_d = (state_d != START_PRESS);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        tmr_load = (state_d != state_q);
        tmr_val  = state_dur(state_d);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            dig_q    <= '0;
            keys_q   <= '0;
            startn_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dig_q    <= dig_d;
            keys_q   <= keys_d;
            startn_q <= startn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.keys   = keys_q;
    assign bus.startn = startn_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule
